shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: word length in bits; legal range 1..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = serialize bit WIDTH-1 first; 0 = bit 0 first.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: parallel word offered.
REQ-006 Port in_ready, output, 1: controller can accept a word.
REQ-007 Port in_data, input, WIDTH: parallel word.
REQ-008 Port shift_en, input, 1: bit-advance strobe (tick) from the consumer.
REQ-009 Port sout, output, 1: current serial bit.
REQ-010 Port sout_valid, output, 1: sout holds a valid data bit.
REQ-011 Port busy, output, 1: a word is in flight (SHIFT or DONE).
REQ-012 Port done, output, 1: one-cycle pulse after the last bit is consumed.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE; fully encoded; no other reachable state.
REQ-014 IDLE: in_ready=1, busy=0, sout_valid=0, sout=0.
REQ-015 Transfer occurs at the rising edge where in_valid=1 and in_ready=1; in_data is captured into the shift register, bit counter is set to 0, and the state goes to SHIFT.
REQ-016 Latency: sout_valid=1 and sout=first bit in the cycle immediately after the transfer edge.
REQ-017 SHIFT: in_ready=0, busy=1, sout_valid=1; sout = register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0).
REQ-018 SHIFT, shift_en=1, counter<WIDTH-1: shift the register one position toward the output end and increment the counter; the vacated bit fills with 0.
REQ-019 SHIFT, shift_en=1, counter=WIDTH-1: go to DONE; do not shift the register.
REQ-020 SHIFT, shift_en=0: hold the register, counter and sout unchanged, for any number of cycles.
REQ-021 DONE: done=1, busy=1, in_ready=0, sout_valid=0, sout=0; unconditional next state IDLE.
REQ-022 Back-to-back throughput: a new word is accepted no earlier than the cycle after DONE, so the minimum period is WIDTH+2 cycles per word.
REQ-023 in_valid while in_ready=0 is ignored and in_data is not sampled; the source holds the word.
REQ-024 shift_en in IDLE or DONE is ignored.
REQ-025 Counter width is max(1,$clog2(WIDTH)); the counter never exceeds WIDTH-1.
REQ-026 WIDTH=1: the first shift_en in SHIFT goes directly to DONE.
REQ-027 All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Reset
REQ-028 rst low asynchronously forces IDLE, counter=0 and register=0; outputs become in_ready=1, busy=0, sout_valid=0, sout=0, done=0.
REQ-029 rst asserted mid-SHIFT or in DONE aborts the word; no done pulse is emitted.
REQ-030 On rst deassertion, the first transfer can occur at the first rising edge.

Structure
REQ-031 Package shift_seq_pkg holds the state enum (IDLE, SHIFT, DONE) and the WIDTH limit constants.
REQ-032 The datapath is a sub-module shift_reg_piso with ports clk, rst, load, shift, d[WIDTH], q_out, parameter MSB_FIRST, built from async-reset flops.
REQ-033 shift_seq_ctrl contains the FSM, counter and handshake only, and instantiates one shift_reg_piso.

Verification
REQ-034 WIDTH=8, MSB_FIRST=1, in_data=8'hA5, shift_en held at 1 -> sout sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then done=1 exactly once, then in_ready=1.
REQ-035 MSB_FIRST=0, in_data=8'hA5, shift_en=1 every 3rd cycle -> sout 1,0,1,0,0,1,0,1 with each bit held 3 cycles; sout_valid stays high throughout.
REQ-036 While in SHIFT, drive in_valid=1 with in_data=8'hFF -> word not accepted, 8'hA5 completes unchanged, and 8'hFF is accepted in the cycle after DONE.
REQ-037 Drop rst low after 3 bits have been shifted -> all outputs reach their reset values immediately, done never pulses, and a new 8'h3C then serializes correctly.
REQ-038 WIDTH=1, in_data=1 -> sout=1 for one cycle with shift_en=1, then done pulse, then IDLE.
REQ-039 Continuous in_valid with words 8'h01, 8'h80 -> accept edges 10 cycles apart, and both serialize correctly.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the serializer controller.
package shift_seq_pkg;

   // Supported word lengths.
   localparam int unsigned WidthMin = 1;
   localparam int unsigned WidthMax = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   // Bit counter width: max(1, clog2(width)).
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out shift register; load wins over shift.
module shift_reg_piso #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             q_out
);

   logic [WIDTH-1:0] reg_q, reg_d;

   // Next-state: capture a word or move one bit toward the output end, filling with 0.
   always_comb begin
      reg_d = reg_q;
      if (load) begin
         reg_d = d;
      end else if (shift) begin
         reg_d = MSB_FIRST ? (reg_q << 1) : (reg_q >> 1);
      end
   end

   // Register with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_q <= '0;
      end else begin
         reg_q <= reg_d;
      end
   end

   assign q_out = MSB_FIRST ? reg_q[WIDTH-1] : reg_q[0];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serializer controller: valid/ready word intake, per-tick bit advance, done pulse.
// WIDTH must lie within WidthMin..WidthMax.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             shift_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned     CntW    = cnt_width(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            load;
   logic            shift;
   logic            q_out;

   // Next-state, counter and datapath strobes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      shift   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            if (shift_en) begin
               // Last bit consumed: leave the register untouched.
               if (cnt_q == CntLast) begin
                  state_d = StDone;
               end else begin
                  shift = 1'b1;
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   shift_reg_piso #(
      .WIDTH    (WIDTH),
      .MSB_FIRST(MSB_FIRST)
   ) u_piso (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .shift(shift),
      .d    (in_data),
      .q_out(q_out)
   );

   // Outputs decode state only; sout is masked to 0 outside SHIFT.
   always_comb begin
      in_ready   = (state_q == StIdle);
      busy       = (state_q != StIdle);
      sout_valid = (state_q == StShift);
      done       = (state_q == StDone);
      sout       = sout_valid & q_out;
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: three instances (8b MSB-first, 8b LSB-first, 1b).
module tb_shift_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   logic       msb_valid, msb_ready, msb_shift, msb_sout, msb_sval, msb_busy, msb_done;
   logic [7:0] msb_data;
   logic       lsb_valid, lsb_ready, lsb_shift, lsb_sout, lsb_sval, lsb_busy, lsb_done;
   logic [7:0] lsb_data;
   logic       w1_valid, w1_ready, w1_shift, w1_sout, w1_sval, w1_busy, w1_done;
   logic [0:0] w1_data;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   shift_seq_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst_n), .in_valid(msb_valid), .in_ready(msb_ready), .in_data(msb_data),
      .shift_en(msb_shift), .sout(msb_sout), .sout_valid(msb_sval), .busy(msb_busy),
      .done(msb_done)
   );

   shift_seq_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst_n), .in_valid(lsb_valid), .in_ready(lsb_ready), .in_data(lsb_data),
      .shift_en(lsb_shift), .sout(lsb_sout), .sout_valid(lsb_sval), .busy(lsb_busy),
      .done(lsb_done)
   );

   shift_seq_ctrl #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
      .clk(clk), .rst(rst_n), .in_valid(w1_valid), .in_ready(w1_ready), .in_data(w1_data),
      .shift_en(w1_shift), .sout(w1_sout), .sout_valid(w1_sval), .busy(w1_busy),
      .done(w1_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observed {in_ready, busy, sout_valid, sout, done} for u_msb.
   function automatic logic [4:0] msb_outs();
      return {msb_ready, msb_busy, msb_sval, msb_sout, msb_done};
   endfunction

   // Starts just after the accept edge with msb_shift=1; ends with DONE observed.
   task automatic ser_msb(input string tag, input logic [7:0] w);
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_bit"}, {30'd0, msb_sval, msb_sout}, {30'd0, 1'b1, w[7-i]});
         step();
      end
      chk({tag, "_done"}, {27'd0, msb_outs()}, {27'd0, 5'b01001});
   endtask

   initial begin
      logic [7:0] a5;
      int         t0;
      a5        = 8'hA5;
      rst_n     = 1'b0;
      msb_valid = 1'b0; msb_data = '0; msb_shift = 1'b0;
      lsb_valid = 1'b0; lsb_data = '0; lsb_shift = 1'b0;
      w1_valid  = 1'b0; w1_data  = '0; w1_shift  = 1'b0;
      step();
      chk("rst_msb", {27'd0, msb_outs()}, {27'd0, 5'b10000});
      chk("rst_lsb", {27'd0, lsb_ready, lsb_busy, lsb_sval, lsb_sout, lsb_done},
          {27'd0, 5'b10000});
      chk("rst_w1", {27'd0, w1_ready, w1_busy, w1_sval, w1_sout, w1_done}, {27'd0, 5'b10000});
      step();
      #2 rst_n = 1'b1;

      // MSB-first A5 with continuous ticks; also first transfer right after reset release.
      msb_valid = 1'b1; msb_data = 8'hA5; msb_shift = 1'b1;
      step();
      msb_valid = 1'b0;
      ser_msb("a5_cont", 8'hA5);
      step();
      chk("a5_idle", {27'd0, msb_outs()}, {27'd0, 5'b10000});

      // New word offered during SHIFT must wait until after DONE.
      msb_valid = 1'b1; msb_data = 8'hA5;
      step();
      msb_data = 8'hFF;
      ser_msb("a5_hold", 8'hA5);
      step();
      chk("ff_wait_idle", {27'd0, msb_outs()}, {27'd0, 5'b10000});
      step();
      chk("ff_accept", {27'd0, msb_outs()}, {27'd0, 5'b01110});
      msb_valid = 1'b0;
      ser_msb("ff", 8'hFF);
      step();

      // Continuous in_valid: accept edges 10 cycles apart.
      msb_valid = 1'b1; msb_data = 8'h01;
      step();
      t0 = cyc;
      msb_data = 8'h80;
      ser_msb("w01", 8'h01);
      step();
      step();
      chk("w80_accept_busy", {31'd0, msb_busy}, 32'd1);
      chk("accept_spacing", cyc - t0, 32'd10);
      msb_valid = 1'b0;
      ser_msb("w80", 8'h80);
      step();

      // Reset mid-word after 3 bits.
      msb_valid = 1'b1; msb_data = 8'hA5;
      step();
      msb_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("pre_rst_bit", {31'd0, msb_sout}, {31'd0, a5[7-i]});
         step();
      end
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst", {27'd0, msb_outs()}, {27'd0, 5'b10000});
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_no_done", {27'd0, msb_outs()}, {27'd0, 5'b10000});
      end
      #3 rst_n = 1'b1;
      msb_valid = 1'b1; msb_data = 8'h3C;
      step();
      msb_valid = 1'b0;
      ser_msb("w3c", 8'h3C);
      step();
      chk("w3c_idle", {27'd0, msb_outs()}, {27'd0, 5'b10000});
      msb_shift = 1'b0;

      // LSB-first A5, a tick every third cycle.
      lsb_valid = 1'b1; lsb_data = 8'hA5;
      step();
      lsb_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 3; j++) begin
            lsb_shift = (j == 2);
            chk("lsb_bit", {30'd0, lsb_sval, lsb_sout}, {30'd0, 1'b1, a5[i]});
            step();
         end
      end
      lsb_shift = 1'b0;
      chk("lsb_done", {27'd0, lsb_ready, lsb_busy, lsb_sval, lsb_sout, lsb_done},
          {27'd0, 5'b01001});
      step();
      chk("lsb_idle", {31'd0, lsb_ready}, 32'd1);

      // WIDTH=1: ticks in IDLE ignored, hold without tick, first tick ends the word.
      w1_shift = 1'b1;
      step();
      chk("w1_idle_tick", {27'd0, w1_ready, w1_busy, w1_sval, w1_sout, w1_done},
          {27'd0, 5'b10000});
      w1_shift = 1'b0; w1_valid = 1'b1; w1_data = 1'b1;
      step();
      w1_valid = 1'b0;
      chk("w1_bit", {27'd0, w1_ready, w1_busy, w1_sval, w1_sout, w1_done}, {27'd0, 5'b01110});
      step();
      chk("w1_hold", {27'd0, w1_ready, w1_busy, w1_sval, w1_sout, w1_done}, {27'd0, 5'b01110});
      w1_shift = 1'b1;
      step();
      chk("w1_done", {27'd0, w1_ready, w1_busy, w1_sval, w1_sout, w1_done}, {27'd0, 5'b01001});
      step();
      chk("w1_idle", {27'd0, w1_ready, w1_busy, w1_sval, w1_sout, w1_done}, {27'd0, 5'b10000});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
